// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per clock).
// Optional invalid-digit flagging is enabled by defining BCD_TO_BIN_ERR_EN.
module bcd_to_bin_seq #(
  parameter int unsigned N_DIGITS = 3,
  parameter int unsigned BIN_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin,
  output logic                  err
);

  localparam int unsigned BCD_W = 4 * N_DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_sh;
  logic [BIN_W-1:0]   acc_q, acc_d, acc_sh;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BIN_W-1:0]   bin_q, bin_d;

`ifdef BCD_TO_BIN_ERR_EN
  logic               bad_digit_c;
  logic               flag_q, flag_d;
  logic               err_q, err_d;

  // Any input digit above 9 marks the request as invalid.
  always_comb begin
    bad_digit_c = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad_digit_c = 1'b1;
    end
  end
`endif

  // One reverse double-dabble step: shift right, then pull every digit >= 8 down by 3.
  always_comb begin
    acc_sh = {bcd_q[0], acc_q[BIN_W-1:1]};
    bcd_sh = bcd_q >> 1;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (bcd_sh[4*i+3]) bcd_sh[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
`ifdef BCD_TO_BIN_ERR_EN
    flag_d  = flag_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bcd_d   = bcd;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
`ifdef BCD_TO_BIN_ERR_EN
          flag_d  = bad_digit_c;
`endif
        end
      end
      S_SHIFT: begin
        bcd_d = bcd_sh;
        acc_d = acc_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
`ifdef BCD_TO_BIN_ERR_EN
          bin_d   = flag_q ? '0 : acc_sh;
          err_d   = flag_q;
`else
          bin_d   = acc_sh;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
`ifdef BCD_TO_BIN_ERR_EN
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
`ifdef BCD_TO_BIN_ERR_EN
      flag_q  <= flag_d;
      err_q   <= err_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bin  = bin_q;
`ifdef BCD_TO_BIN_ERR_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed scenarios plus a full 0..999 sweep
// with random gaps and random start/bcd activity while busy.
module tb_bcd_to_bin_seq;

  localparam int unsigned N_DIGITS = 3;
  localparam int unsigned BIN_W    = 10;
  localparam int unsigned BCD_W    = 4 * N_DIGITS;
  localparam int          TIMEOUT  = 40;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [BCD_W-1:0] bcd = '0;
  logic             busy, done, err;
  logic [BIN_W-1:0] bin;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [BIN_W-1:0] last_bin = '0;
  logic             last_err = 1'b0;

  bcd_to_bin_seq #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bcd  (bcd),
    .busy (busy),
    .done (done),
    .bin  (bin),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    logic [BCD_W-1:0] r;
    int               x;
    x = v;
    r = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: decimal value of the digits, or (0, err) if any digit is not 0..9.
  function automatic void ref_model(input logic [BCD_W-1:0] v, output logic [BIN_W-1:0] b,
                                    output logic e);
    int acc;
    int w;
    acc = 0;
    w   = 1;
    e   = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) e = 1'b1;
      acc = acc + int'(v[4*i +: 4]) * w;
      w   = w * 10;
    end
    b = e ? '0 : BIN_W'(acc);
  endfunction

  // mode: 0 quiet inputs while busy, 1 random start/bcd while busy, 2 start held high.
  task automatic convert(input logic [BCD_W-1:0] v, input string tag, input int mode);
    logic [BIN_W-1:0] exp_bin;
    logic             exp_err;
    int               k;
    logic             hold_ok;
    ref_model(v, exp_bin, exp_err);
`ifndef BCD_TO_BIN_ERR_EN
    exp_err = 1'b0;
`endif
    start = 1'b1;
    bcd   = v;
    step();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s accept_busy got=%b exp=1", tag, busy);
    end
    hold_ok = 1'b1;
    k = 0;
    while (k < TIMEOUT) begin
      if (mode == 1) begin
        start = 1'($urandom_range(0, 1));
        bcd   = BCD_W'($urandom);
      end else if (mode == 2) begin
        start = 1'b1;
        bcd   = BCD_W'($urandom);
      end
      step();
      k++;
      if (done === 1'b1) break;
      if (busy !== 1'b1 || bin !== last_bin || err !== last_err) hold_ok = 1'b0;
    end
    start = 1'b0;
    n_cmp++;
    if (!hold_ok) begin
      n_bad++;
      $display("FAIL %s hold_while_busy got=0 exp=1", tag);
    end
    n_cmp++;
    if (k != int'(BIN_W) || done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s latency got=%0d done=%b exp=%0d", tag, k, done, BIN_W);
    end
    n_cmp++;
    if (bin !== exp_bin) begin
      n_bad++;
      $display("FAIL %s bin in=%h got=%0d exp=%0d", tag, v, bin, exp_bin);
    end
    n_cmp++;
    if (err !== exp_err) begin
      n_bad++;
      $display("FAIL %s err in=%h got=%b exp=%b", tag, v, err, exp_err);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_at_done got=%b exp=0", tag, busy);
    end
    last_bin = exp_bin;
    last_err = exp_err;
  endtask

  task automatic idle_check(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0 || bin !== last_bin) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL %s idle_quiet got=1 exp=0", tag);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (bin !== '0) begin n_bad++; $display("FAIL reset_bin got=%0d exp=0", bin); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
    rst_n = 1'b1;
    last_bin = '0;
    last_err = 1'b0;
    idle_check(3, "post_reset");
  endtask

  task automatic test_basic();
    convert(12'h255, "conv_255", 0);
    idle_check(2, "after_255");
    convert(12'h999, "conv_999", 0);
    idle_check(1, "after_999");
    convert(12'h000, "conv_000", 0);
    idle_check(1, "after_000");
  endtask

  task automatic test_back_to_back();
    convert(12'h128, "b2b_128", 0);
    convert(12'h064, "b2b_064", 0);
    idle_check(2, "after_b2b");
  endtask

  task automatic test_ignore_start();
    convert(12'h731, "ign_held", 2);
    idle_check(15, "ign_no_extra");
    convert(12'h406, "ign_rand", 1);
    idle_check(15, "ign_rand_no_extra");
  endtask

  task automatic test_reset_mid();
    logic dn;
    start = 1'b1;
    bcd   = 12'h500;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
    n_cmp++; if (bin !== '0) begin n_bad++; $display("FAIL rstmid_bin got=%0d exp=0", bin); end
    dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done !== 1'b0) dn = 1'b1;
    end
    rst_n = 1'b1;
    last_bin = '0;
    last_err = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done !== 1'b0) dn = 1'b1;
    end
    n_cmp++; if (dn) begin n_bad++; $display("FAIL rstmid_no_done got=1 exp=0"); end
    convert(12'h500, "rstmid_new", 0);
  endtask

`ifdef BCD_TO_BIN_ERR_EN
  task automatic test_err();
    convert(12'h9A5, "err_9a5", 0);
    convert(12'h042, "err_042", 0);
    for (int i = 0; i < 200; i++) begin
      convert(BCD_W'($urandom), "err_rand", 1);
      if ($urandom_range(0, 1) == 1) idle_check(int'($urandom_range(1, 2)), "err_gap");
    end
  endtask
`endif

  task automatic test_sweep();
    for (int v = 0; v < 1000; v++) begin
      convert(to_bcd(v), "sweep", int'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle_check(int'($urandom_range(1, 2)), "sweep_gap");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
`ifdef BCD_TO_BIN_ERR_EN
    test_err();
`endif
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
